// File: rtl/buz_seq.sv
// Buzzer tone/beep sequencer: generates a PWM tone in bursts of on_len periods,
// separated by off_len silent periods, repeated beeps times (or until stop).
module buz_seq #(
    parameter int CNT_W  = 16,
    parameter int DUR_W  = 16,
    parameter int BEEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [CNT_W-1:0]  period,
    input  logic [CNT_W-1:0]  duty,
    input  logic [DUR_W-1:0]  on_len,
    input  logic [DUR_W-1:0]  off_len,
    input  logic [BEEP_W-1:0] beeps,
    output logic              buz,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [DUR_W-1:0]  DUR_ONE  = DUR_W'(1);
    localparam logic [BEEP_W-1:0] BEEP_ONE = BEEP_W'(1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n, period_l, duty_l;
    logic [DUR_W-1:0]  pcnt, pcnt_n, on_len_l, off_len_l;
    logic [BEEP_W-1:0] bcnt, bcnt_n, beeps_l;
    logic              load, wrap, done_n, buz_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pcnt_n  = pcnt;
        bcnt_n  = bcnt;
        done_n  = 1'b0;
        load    = 1'b0;
        wrap    = (cnt == period_l);
        buz_n   = (state == TONE) && (cnt >= duty_l);

        if (stop) begin
            state_n = IDLE;
            cnt_n   = '0;
            pcnt_n  = '0;
            bcnt_n  = '0;
            buz_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_n  = '0;
                    pcnt_n = '0;
                    bcnt_n = '0;
                    if (start) begin
                        load    = 1'b1;
                        state_n = TONE;
                    end
                end
                TONE: begin
                    cnt_n = wrap ? '0 : cnt + CNT_ONE;
                    if (wrap) begin
                        if (pcnt == on_len_l - DUR_ONE) begin
                            pcnt_n = '0;
                            if (beeps_l != '0 && bcnt == beeps_l - BEEP_ONE) begin
                                state_n = IDLE;
                                bcnt_n  = '0;
                                done_n  = 1'b1;
                            end else begin
                                bcnt_n  = bcnt + BEEP_ONE;
                                state_n = (off_len_l == '0) ? TONE : GAP;
                            end
                        end else begin
                            pcnt_n = pcnt + DUR_ONE;
                        end
                    end
                end
                GAP: begin
                    cnt_n = wrap ? '0 : cnt + CNT_ONE;
                    // pcnt is reused to count silent periods; cleared again on entry to TONE
                    if (wrap) begin
                        if (pcnt == off_len_l - DUR_ONE) begin
                            pcnt_n  = '0;
                            state_n = TONE;
                        end else begin
                            pcnt_n = pcnt + DUR_ONE;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    pcnt_n  = '0;
                    bcnt_n  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pcnt      <= '0;
            bcnt      <= '0;
            period_l  <= '0;
            duty_l    <= '0;
            on_len_l  <= '0;
            off_len_l <= '0;
            beeps_l   <= '0;
            buz       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pcnt  <= pcnt_n;
            bcnt  <= bcnt_n;
            buz   <= buz_n;
            busy  <= (state_n != IDLE);
            done  <= done_n;
            if (load) begin
                period_l  <= (period == '0) ? CNT_ONE : period;
                duty_l    <= duty;
                on_len_l  <= (on_len == '0) ? DUR_ONE : on_len;
                off_len_l <= off_len;
                beeps_l   <= beeps;
            end
        end
    end

endmodule
